// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer and two-client round-robin arbiter for a bank of
// high-transparent D latches. Each write runs setup -> open -> hold so that
// LAT_D is never changing while any latch enable is high.
module latch_bank_wr_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic [AW-1:0]    ADDR0,
  input  logic [WIDTH-1:0] DIN0,
  input  logic             REQ1,
  input  logic [AW-1:0]    ADDR1,
  input  logic [WIDTH-1:0] DIN1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [DEPTH-1:0] LAT_EN,
  output logic [WIDTH-1:0] LAT_D,
  output logic             BUSY
);

  localparam int unsigned DEPTH_U = DEPTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic [AW-1:0]    addr_q,   addr_d;
  logic [WIDTH-1:0] lat_d_q,  lat_d_d;
  logic [DEPTH-1:0] lat_en_q, lat_en_d;
  logic             done0_q,  done0_d;
  logic             done1_q,  done1_d;
  logic             busy_q,   busy_d;
  logic             gnt_q,    gnt_d;   // client owning the write in flight
  logic             last_q,   last_d;  // client served most recently

  // Next-state and next-output computation; every output is a flop so the
  // values below take effect one edge later, giving the setup/open/hold spacing.
  always_comb begin
    logic win;
    state_d  = state_q;
    addr_d   = addr_q;
    lat_d_d  = lat_d_q;
    lat_en_d = '0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    busy_d   = busy_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    win      = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ0 || REQ1) begin
          // Tie goes to whoever was not served last; a lone request always wins.
          if (REQ0 && REQ1) win = ~last_q;
          else              win = REQ1;
          gnt_d   = win;
          addr_d  = win ? ADDR1 : ADDR0;
          lat_d_d = win ? DIN1  : DIN0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // Out-of-range addresses match no bit, so the write is silently dropped.
        for (int unsigned i = 0; i < DEPTH_U; i++) begin
          lat_en_d[i] = (32'(addr_q) == i);
        end
        state_d = OPEN;
      end
      OPEN: begin
        done0_d = ~gnt_q;
        done1_d = gnt_q;
        last_d  = gnt_q;
        state_d = HOLD;
      end
      HOLD: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset closes every latch immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      lat_d_q  <= '0;
      lat_en_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lat_d_q  <= lat_d_d;
      lat_en_q <= lat_en_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
    end
  end

  assign DONE0  = done0_q;
  assign DONE1  = done1_q;
  assign LAT_EN = lat_en_q;
  assign LAT_D  = lat_d_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_latch_bank_wr_ctrl.sv
// Scoreboard bench for latch_bank_wr_ctrl: stimulus pushes expected writes,
// monitors pop them on DONE pulses. A second instance covers DEPTH=3.
module tb_latch_bank_wr_ctrl;

  typedef struct {
    int unsigned client;
    logic [3:0]  en;
    logic [7:0]  d;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] din0 = '0, din1 = '0;
  logic       done0, done1, busy;
  logic [3:0] lat_en;
  logic [7:0] lat_d;

  logic       reqb1 = 1'b0;
  logic [1:0] addrb1 = '0;
  logic [7:0] dinb1 = '0;
  logic       done0b, done1b, busyb;
  logic [2:0] lat_enb;
  logic [7:0] lat_db;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t exp_q[$];
  exp_t expb_q[$];
  logic [7:0] bank [4];
  logic [7:0] bank_b [3];

  latch_bank_wr_ctrl #(.WIDTH(8), .DEPTH(4), .AW(2)) dut (
    .CLK(clk), .RST(rst),
    .REQ0(req0), .ADDR0(addr0), .DIN0(din0),
    .REQ1(req1), .ADDR1(addr1), .DIN1(din1),
    .DONE0(done0), .DONE1(done1), .LAT_EN(lat_en), .LAT_D(lat_d), .BUSY(busy)
  );

  latch_bank_wr_ctrl #(.WIDTH(8), .DEPTH(3), .AW(2)) dut_b (
    .CLK(clk), .RST(rst),
    .REQ0(1'b0), .ADDR0(2'b00), .DIN0(8'h00),
    .REQ1(reqb1), .ADDR1(addrb1), .DIN1(dinb1),
    .DONE0(done0b), .DONE1(done1b), .LAT_EN(lat_enb), .LAT_D(lat_db), .BUSY(busyb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Bank models: a latch entry takes LAT_D whenever its enable is seen high.
  initial begin
    for (int i = 0; i < 4; i++) bank[i] = '0;
    for (int i = 0; i < 3; i++) bank_b[i] = '0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) if (lat_en[i]) bank[i] = lat_d;
    for (int i = 0; i < 3; i++) if (lat_enb[i]) bank_b[i] = lat_db;
  end

  // Scoreboard monitor, main instance.
  logic [3:0] seen_en = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) seen_en = '0;
    else begin
      if (lat_en != '0) seen_en = lat_en;
      if (done0 || done1) begin
        chk("done_exclusive", 32'(done0 & done1), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: actual=%b%b required=none", done1, done0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_client", 32'(done1), e.client);
          chk("sb_lat_en", 32'(seen_en), 32'(e.en));
          chk("sb_lat_d", 32'(lat_d), 32'(e.d));
        end
        seen_en = '0;
      end
    end
  end

  // Scoreboard monitor, DEPTH=3 instance.
  logic [2:0] seen_enb = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) seen_enb = '0;
    else begin
      if (lat_enb != '0) seen_enb = lat_enb;
      if (done0b || done1b) begin
        if (expb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done_b: actual=%b%b required=none", done1b, done0b);
        end else begin
          e = expb_q.pop_front();
          chk("sbb_client", 32'(done1b), e.client);
          chk("sbb_lat_en", 32'(seen_enb), 32'(e.en));
          chk("sbb_lat_d", 32'(lat_db), 32'(e.d));
        end
        seen_enb = '0;
      end
    end
  end

  // Bank-side guarantees: one-hot enables, LAT_D steady around an open window.
  logic [3:0] prev_en = '0;
  logic [7:0] prev_d = '0, prev2_d = '0;
  always @(negedge clk) begin
    if (rst) prev_en = '0;
    else begin
      if (lat_en != '0) chk("onehot", 32'($countones(lat_en)), 32'd1);
      if (prev_en != '0) begin
        chk("d_stable_after", 32'(lat_d), 32'(prev_d));
        chk("d_stable_before", 32'(prev_d), 32'(prev2_d));
      end
      prev_en = lat_en;
    end
    prev2_d = prev_d;
    prev_d  = lat_d;
  end

  task automatic wait_done(input bit use_b, output int at_cyc);
    bit got = 1'b0;
    int n = 0;
    at_cyc = 0;
    while (!got && n < 24) begin
      @(negedge clk);
      n++;
      if (use_b ? (done0b || done1b) : (done0 || done1)) begin
        got = 1'b1;
        at_cyc = cyc;
      end
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c_prev, c_now;
    bit seen;

    @(negedge clk);
    chk("rst_lat_en", 32'(lat_en), 32'd0);
    chk("rst_lat_d", 32'(lat_d), 32'd0);
    chk("rst_done", 32'({done1, done0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single write: client 0, entry 2, A5.
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd2; din0 = 8'hA5;
    exp_q.push_back('{0, 4'b0100, 8'hA5});
    @(negedge clk);
    chk("sw_setup_d", 32'(lat_d), 32'hA5);
    chk("sw_setup_en", 32'(lat_en), 32'd0);
    chk("sw_setup_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("sw_open_en", 32'(lat_en), 32'b0100);
    @(negedge clk);
    chk("sw_hold_done0", 32'(done0), 32'd1);
    chk("sw_hold_en", 32'(lat_en), 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    chk("sw_idle_done0", 32'(done0), 32'd0);
    chk("sw_idle_busy", 32'(busy), 32'd0);
    chk("sw_idle_d", 32'(lat_d), 32'hA5);
    chk("sw_bank2", 32'(bank[2]), 32'hA5);

    // Tie arbitration from a fresh reset: 0,1,0,1 with 4-cycle spacing.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; addr0 = 2'd0; din0 = 8'h11;
    req1 = 1'b1; addr1 = 2'd1; din1 = 8'h22;
    exp_q.push_back('{0, 4'b0001, 8'h11});
    exp_q.push_back('{1, 4'b0010, 8'h22});
    exp_q.push_back('{0, 4'b0001, 8'h11});
    exp_q.push_back('{1, 4'b0010, 8'h22});
    c_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(1'b0, c_now);
      chk("tie_winner", 32'(done1), 32'(k % 2));
      if (k > 0) chk("tie_spacing", 32'(c_now - c_prev), 32'd4);
      c_prev = c_now;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);

    // Stability: DIN0 toggles every cycle, LAT_D keeps the grant-edge value.
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd3; din0 = 8'h33;
    exp_q.push_back('{0, 4'b1000, 8'h33});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stab_lat_d", 32'(lat_d), 32'h33);
      din0 = ~din0;
    end
    chk("stab_done0", 32'(done0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);

    // Early drop of REQ1 and REQ0 held across DONE0.
    @(negedge clk);
    req0 = 1'b1; addr0 = 2'd1; din0 = 8'h44;
    exp_q.push_back('{0, 4'b0010, 8'h44});
    exp_q.push_back('{0, 4'b0010, 8'h44});
    @(negedge clk);
    req1 = 1'b1; addr1 = 2'd2; din1 = 8'h55;
    @(negedge clk);
    req1 = 1'b0;
    wait_done(1'b0, c_prev);
    wait_done(1'b0, c_now);
    chk("rerun_spacing", 32'(c_now - c_prev), 32'd4);
    req0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("late_bank2_kept", 32'(bank[2]), 32'hA5);
    chk("late_bank1", 32'(bank[1]), 32'h44);

    // Reset during OPEN: enables, busy and data clear at once, no DONE.
    req0 = 1'b1; addr0 = 2'd0; din0 = 8'h66;
    exp_q.push_back('{0, 4'b0001, 8'h66});
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (lat_en != '0) seen = 1'b1;
    end
    chk("mid_open_seen", 32'(seen), 32'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_lat_en", 32'(lat_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_lat_d", 32'(lat_d), 32'd0);
    chk("mid_rst_bank0", 32'(bank[0]), 32'h66);
    din0 = 8'h77;
    @(negedge clk);
    chk("mid_rst_no_done", 32'({done1, done0}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back('{0, 4'b0001, 8'h77});
    wait_done(1'b0, c_now);
    chk("post_rst_done0", 32'(done0), 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("post_rst_bank0", 32'(bank[0]), 32'h77);

    // DEPTH=3 instance: a valid write, then an out-of-range one that is dropped.
    @(negedge clk);
    reqb1 = 1'b1; addrb1 = 2'd1; dinb1 = 8'h5A;
    expb_q.push_back('{1, 4'b0010, 8'h5A});
    wait_done(1'b1, c_now);
    reqb1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reqb1 = 1'b1; addrb1 = 2'd3; dinb1 = 8'h99;
    expb_q.push_back('{1, 4'b0000, 8'h99});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("oor_lat_en", 32'(lat_enb), 32'd0);
    end
    chk("oor_done1", 32'(done1b), 32'd1);
    reqb1 = 1'b0;
    @(negedge clk);
    chk("oor_bank0", 32'(bank_b[0]), 32'h00);
    chk("oor_bank1", 32'(bank_b[1]), 32'h5A);
    chk("oor_bank2", 32'(bank_b[2]), 32'h00);

    repeat (4) @(negedge clk);
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    chk("final_queue_b", 32'(expb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
